// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory-access stage: op encoding, size codes,
// FSM state encoding and datapath widths.
package lsu_mem_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned DEST_W = 5;
    localparam int unsigned BE_W   = 4;
    // Holds RD_LATENCY-1 for the legal range 1..4.
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } size_e;

    // Bit layout matches exe_op: {is_store, unsigned, size[1:0]}.
    typedef struct packed {
        logic  is_store;
        logic  is_unsigned;
        size_e size;
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WAIT   = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational byte-lane logic for the LSU.
//   size/is_unsigned/addr_lo : access descriptor
//   wdata                    : right-aligned store data
//   rdata                    : raw SRAM read word
//   ale_c                    : misaligned or illegal size
//   mask_c / sdata_c         : store byte enables and lane-replicated store data
//   ldata_c                  : extracted and extended load result
module lsu_align
    import lsu_mem_stage_pkg::*;
(
    input  size_e             size,
    input  logic              is_unsigned,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic              ale_c,
    output logic [BE_W-1:0]   mask_c,
    output logic [XLEN-1:0]   sdata_c,
    output logic [XLEN-1:0]   ldata_c
);

    logic [XLEN-1:0] lane;

    // Addressed byte/halfword moved down to bit 0.
    assign lane = rdata >> {addr_lo, 3'b000};

    always_comb begin
        ale_c   = 1'b0;
        mask_c  = '0;
        sdata_c = wdata;
        ldata_c = '0;
        case (size)
            SIZE_B: begin
                mask_c  = 4'b0001 << addr_lo;
                sdata_c = {4{wdata[7:0]}};
                ldata_c = is_unsigned ? {24'b0, lane[7:0]}
                                      : {{24{lane[7]}}, lane[7:0]};
            end
            SIZE_H: begin
                ale_c   = addr_lo[0];
                mask_c  = 4'b0011 << {addr_lo[1], 1'b0};
                sdata_c = {2{wdata[15:0]}};
                ldata_c = is_unsigned ? {16'b0, lane[15:0]}
                                      : {{16{lane[15]}}, lane[15:0]};
            end
            SIZE_W: begin
                ale_c   = |addr_lo;
                mask_c  = 4'b1111;
                sdata_c = wdata;
                ldata_c = rdata;
            end
            default: begin
                ale_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// LSU memory-access stage between EXE and WB of the multi-cycle core.
// Accepts one request per handshake, drives the data SRAM, waits out the read
// latency and returns an extended load result (or an ALE flag) to WB.
//   clk, reset (sync, active-high)
//   exe_*            : request from EXE, sampled only while exe_ready=1
//   data_sram_*      : data SRAM strobe, byte enables, word address, store data, read data
//   wb_*             : registered result to WB, held until wb_valid & wb_ready
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exe_valid,
    output logic              exe_ready,
    input  logic [OP_W-1:0]   exe_op,
    input  logic [XLEN-1:0]   exe_addr,
    input  logic [XLEN-1:0]   exe_wdata,
    input  logic [DEST_W-1:0] exe_dest,
    input  logic [XLEN-1:0]   exe_pc,
    output logic              data_sram_en,
    output logic [BE_W-1:0]   data_sram_we,
    output logic [XLEN-1:0]   data_sram_addr,
    output logic [XLEN-1:0]   data_sram_wdata,
    input  logic [XLEN-1:0]   data_sram_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_is_load,
    output logic [XLEN-1:0]   wb_rdata,
    output logic [DEST_W-1:0] wb_dest,
    output logic [XLEN-1:0]   wb_pc,
    output logic              wb_ale
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept_c;
    logic              capture_c;

    mem_op_t           exe_op_s;
    mem_op_t           op_q, op_d;
    logic [1:0]        addr_lo_q, addr_lo_d;

    mem_op_t           al_op;
    logic [1:0]        al_addr_lo;
    logic              ale_c;
    logic [BE_W-1:0]   mask_c;
    logic [XLEN-1:0]   sdata_c;
    logic [XLEN-1:0]   ldata_c;

    logic              exe_ready_q, exe_ready_d;
    logic              sram_en_q, sram_en_d;
    logic [BE_W-1:0]   sram_we_q, sram_we_d;
    logic [XLEN-1:0]   sram_addr_q, sram_addr_d;
    logic [XLEN-1:0]   sram_wdata_q, sram_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_is_load_q, wb_is_load_d;
    logic [XLEN-1:0]   wb_rdata_q, wb_rdata_d;
    logic [DEST_W-1:0] wb_dest_q, wb_dest_d;
    logic [XLEN-1:0]   wb_pc_q, wb_pc_d;
    logic              wb_ale_q, wb_ale_d;

    assign exe_op_s = mem_op_t'(exe_op);

    // In IDLE the lane logic looks at the incoming request; afterwards at the latched one.
    assign al_op      = (state_q == ST_IDLE) ? exe_op_s       : op_q;
    assign al_addr_lo = (state_q == ST_IDLE) ? exe_addr[1:0]  : addr_lo_q;

    lsu_align u_align (
        .size        (al_op.size),
        .is_unsigned (al_op.is_unsigned),
        .addr_lo     (al_addr_lo),
        .wdata       (exe_wdata),
        .rdata       (data_sram_rdata),
        .ale_c       (ale_c),
        .mask_c      (mask_c),
        .sdata_c     (sdata_c),
        .ldata_c     (ldata_c)
    );

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exe_valid) begin
                    accept_c = 1'b1;
                    state_d  = ale_c ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (op_q.is_store) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = CNT_LOAD;
                    if (RD_LATENCY <= 1) begin
                        // Read data is already valid on the edge that leaves ACCESS.
                        capture_c = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Counter reaching zero marks the edge on which rdata is valid.
                if (cnt_q == CNT_W'(1)) begin
                    capture_c = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and request-register next values, decoded from the next state.
    always_comb begin
        exe_ready_d  = (state_d == ST_IDLE);
        sram_en_d    = (state_d == ST_ACCESS);
        sram_we_d    = '0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        wb_valid_d   = (state_d == ST_DONE);
        wb_is_load_d = wb_is_load_q;
        wb_rdata_d   = wb_rdata_q;
        wb_dest_d    = wb_dest_q;
        wb_pc_d      = wb_pc_q;
        wb_ale_d     = wb_ale_q;
        op_d         = op_q;
        addr_lo_d    = addr_lo_q;

        // ACCESS is only ever entered from IDLE, so al_op is the incoming request here.
        if ((state_d == ST_ACCESS) && al_op.is_store) begin
            sram_we_d = mask_c;
        end

        if (accept_c) begin
            op_d         = exe_op_s;
            addr_lo_d    = exe_addr[1:0];
            sram_addr_d  = {exe_addr[XLEN-1:2], 2'b00};
            sram_wdata_d = sdata_c;
            wb_is_load_d = ~exe_op_s.is_store & ~ale_c;
            wb_ale_d     = ale_c;
            wb_rdata_d   = '0;
            wb_dest_d    = exe_dest;
            wb_pc_d      = exe_pc;
        end else if (capture_c) begin
            wb_rdata_d   = ldata_c;
        end
    end

    // Output and request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_ready_q  <= 1'b1;
            sram_en_q    <= 1'b0;
            sram_we_q    <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_is_load_q <= 1'b0;
            wb_rdata_q   <= '0;
            wb_dest_q    <= '0;
            wb_pc_q      <= '0;
            wb_ale_q     <= 1'b0;
            op_q         <= '0;
            addr_lo_q    <= '0;
        end else begin
            exe_ready_q  <= exe_ready_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_is_load_q <= wb_is_load_d;
            wb_rdata_q   <= wb_rdata_d;
            wb_dest_q    <= wb_dest_d;
            wb_pc_q      <= wb_pc_d;
            wb_ale_q     <= wb_ale_d;
            op_q         <= op_d;
            addr_lo_q    <= addr_lo_d;
        end
    end

    assign exe_ready       = exe_ready_q;
    assign data_sram_en    = sram_en_q;
    assign data_sram_we    = sram_we_q;
    assign data_sram_addr  = sram_addr_q;
    assign data_sram_wdata = sram_wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_is_load      = wb_is_load_q;
    assign wb_rdata        = wb_rdata_q;
    assign wb_dest         = wb_dest_q;
    assign wb_pc           = wb_pc_q;
    assign wb_ale          = wb_ale_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: one instance with RD_LATENCY=1, one with 3.
// Expected results are queued at issue time and popped when wb_valid appears.
module tb_lsu_mem_stage;

    logic        clk;
    logic        reset;
    logic        exe_valid1, exe_valid3;
    logic [3:0]  exe_op;
    logic [31:0] exe_addr, exe_wdata, exe_pc;
    logic [4:0]  exe_dest;
    logic        wb_ready;
    logic [31:0] sram_word;

    logic        rdy1, en1, wbv1, wbl1, ale1;
    logic [3:0]  we1;
    logic [31:0] saddr1, swd1, rd1, wbr1, wbpc1;
    logic [4:0]  wbd1;
    logic        rdy3, en3, wbv3, wbl3, ale3;
    logic [3:0]  we3;
    logic [31:0] saddr3, swd3, rd3, wbr3, wbpc3;
    logic [4:0]  wbd3;
    logic [1:0]  h3;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_mem_stage #(.RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .exe_valid(exe_valid1), .exe_ready(rdy1), .exe_op(exe_op), .exe_addr(exe_addr),
        .exe_wdata(exe_wdata), .exe_dest(exe_dest), .exe_pc(exe_pc),
        .data_sram_en(en1), .data_sram_we(we1), .data_sram_addr(saddr1),
        .data_sram_wdata(swd1), .data_sram_rdata(rd1),
        .wb_valid(wbv1), .wb_ready(wb_ready), .wb_is_load(wbl1), .wb_rdata(wbr1),
        .wb_dest(wbd1), .wb_pc(wbpc1), .wb_ale(ale1)
    );

    lsu_mem_stage #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .exe_valid(exe_valid3), .exe_ready(rdy3), .exe_op(exe_op), .exe_addr(exe_addr),
        .exe_wdata(exe_wdata), .exe_dest(exe_dest), .exe_pc(exe_pc),
        .data_sram_en(en3), .data_sram_we(we3), .data_sram_addr(saddr3),
        .data_sram_wdata(swd3), .data_sram_rdata(rd3),
        .wb_valid(wbv3), .wb_ready(wb_ready), .wb_is_load(wbl3), .wb_rdata(wbr3),
        .wb_dest(wbd3), .wb_pc(wbpc3), .wb_ale(ale3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: data is valid only in the cycle RD_LATENCY-1 edges after en, garbage otherwise.
    assign rd1 = (en1 === 1'b1) ? sram_word : 32'hDEAD_BEEF;
    always_ff @(posedge clk) h3 <= {h3[0], en3};
    assign rd3 = (h3[1] === 1'b1) ? sram_word : 32'hDEAD_BEEF;

    // Selected-instance view.
    logic        sel;
    logic        o_rdy, o_en, o_wbv, o_wbl, o_ale;
    logic [3:0]  o_we;
    logic [31:0] o_saddr, o_swd, o_wbr, o_wbpc;
    logic [4:0]  o_wbd;
    assign o_rdy   = sel ? rdy3   : rdy1;
    assign o_en    = sel ? en3    : en1;
    assign o_wbv   = sel ? wbv3   : wbv1;
    assign o_wbl   = sel ? wbl3   : wbl1;
    assign o_ale   = sel ? ale3   : ale1;
    assign o_we    = sel ? we3    : we1;
    assign o_saddr = sel ? saddr3 : saddr1;
    assign o_swd   = sel ? swd3   : swd1;
    assign o_wbr   = sel ? wbr3   : wbr1;
    assign o_wbpc  = sel ? wbpc3  : wbpc1;
    assign o_wbd   = sel ? wbd3   : wbd1;

    typedef struct {
        logic        is_load;
        logic        ale;
        logic [31:0] rdata;
        logic [4:0]  dest;
        logic [31:0] pc;
        int          en_cnt;
        int          lat;
        logic [3:0]  we;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic        is_store;
    } exp_t;

    exp_t sb[$];
    int   seq = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, follow it to wb_valid, compare against the queued expectation.
    task automatic run(input logic s, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word,
                       input logic [3:0] exp_we, input logic [31:0] exp_swd,
                       input logic [31:0] exp_rdata, input logic exp_ale, input int hold);
        exp_t        e;
        exp_t        g;
        int          k;
        int          n;
        int          en_cnt;
        logic        rdy_bad;
        logic [3:0]  got_we;
        logic [31:0] got_addr, got_swd;

        sel = s;
        seq++;
        e.is_store = op[3];
        e.ale      = exp_ale;
        e.is_load  = ~op[3] & ~exp_ale;
        e.rdata    = exp_rdata;
        e.dest     = 5'(seq);
        e.pc       = 32'h1c00_0000 + 32'(seq * 4);
        e.en_cnt   = exp_ale ? 0 : 1;
        e.lat      = exp_ale ? 1 : (op[3] ? 2 : (s ? 4 : 2));
        e.we       = exp_we;
        e.saddr    = {addr[31:2], 2'b00};
        e.swdata   = exp_swd;
        sb.push_back(e);

        wb_ready = (hold == 0);
        n = 0;
        while (!o_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("exe_ready_idle", 32'(o_rdy), 32'd1);

        exe_op    = op;
        exe_addr  = addr;
        exe_wdata = wdata;
        exe_dest  = 5'(seq);
        exe_pc    = 32'h1c00_0000 + 32'(seq * 4);
        sram_word = word;
        if (s) exe_valid3 = 1'b1; else exe_valid1 = 1'b1;
        @(negedge clk);
        exe_valid1 = 1'b0;
        exe_valid3 = 1'b0;
        // Must be ignored while busy.
        exe_op    = 4'b1010;
        exe_addr  = ~addr;
        exe_wdata = 32'h5555_AAAA;
        exe_dest  = ~exe_dest;
        exe_pc    = ~exe_pc;

        k = 1; en_cnt = 0; rdy_bad = 1'b0;
        got_we = '0; got_addr = '0; got_swd = '0;
        while (k <= 12) begin
            if (o_en) begin
                en_cnt++;
                got_we = o_we; got_addr = o_saddr; got_swd = o_swd;
            end
            if (o_wbv) break;
            if (o_rdy) rdy_bad = 1'b1;
            @(negedge clk);
            k++;
        end

        g = sb.pop_front();
        chk("wb_valid",   32'(o_wbv), 32'd1);
        chk("latency",    32'(k), 32'(g.lat));
        chk("en_pulses",  32'(en_cnt), 32'(g.en_cnt));
        chk("busy_ready", 32'(rdy_bad), 32'd0);
        if (g.en_cnt > 0) begin
            chk("sram_we",   32'(got_we), 32'(g.we));
            chk("sram_addr", got_addr, g.saddr);
            if (g.is_store) chk("sram_wdata", got_swd, g.swdata);
        end
        chk("wb_is_load", 32'(o_wbl), 32'(g.is_load));
        chk("wb_ale",     32'(o_ale), 32'(g.ale));
        chk("wb_rdata",   o_wbr, g.rdata);
        chk("wb_dest",    32'(o_wbd), 32'(g.dest));
        chk("wb_pc",      o_wbpc, g.pc);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_state", {o_wbv, o_rdy, o_wbl, o_ale, 28'(o_wbd)}, {1'b1, 1'b0, g.is_load, g.ale, 28'(g.dest)});
            chk("hold_data",  o_wbr ^ o_wbpc, g.rdata ^ g.pc);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("after_hs", {30'd0, o_wbv, o_rdy}, 32'b01);
    endtask

    initial begin
        int   cnt_bad;
        reset = 1'b1; exe_valid1 = 1'b0; exe_valid3 = 1'b0;
        exe_op = '0; exe_addr = '0; exe_wdata = '0; exe_dest = '0; exe_pc = '0;
        wb_ready = 1'b1; sram_word = '0; sel = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_dut1", {25'd0, rdy1, en1, we1 == 4'd0, wbv1, ale1, wbl1, wbr1 == 32'd0}, {25'd0, 7'b1010001});
        chk("rst_dut3", {25'd0, rdy3, en3, we3 == 4'd0, wbv3, ale3, wbl3, wbr3 == 32'd0}, {25'd0, 7'b1010001});
        reset = 1'b0;
        @(negedge clk);

        // Stores.
        run(1'b0, 4'b1010, 32'h1c00_0010, 32'h1234_5678, 32'h0, 4'b1111, 32'h1234_5678, 32'h0, 1'b0, 0);
        run(1'b0, 4'b1000, 32'h1c00_0023, 32'h1234_56AB, 32'h0, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0, 0);
        run(1'b0, 4'b1001, 32'h1c00_0022, 32'h7777_BEEF, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 0);
        run(1'b0, 4'b1000, 32'h1c00_0021, 32'h0000_0011, 32'h0, 4'b0010, 32'h1111_1111, 32'h0, 1'b0, 0);

        // Loads from word 0x80FF_7F01, RD_LATENCY=1.
        run(1'b0, 4'b0000, 32'h1c00_0101, 32'h0, 32'h80FF_7F01, 4'b0000, 32'h0, 32'h0000_007F, 1'b0, 0);
        run(1'b0, 4'b0000, 32'h1c00_0102, 32'h0, 32'h80FF_7F01, 4'b0000, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
        run(1'b0, 4'b0100, 32'h1c00_0103, 32'h0, 32'h80FF_7F01, 4'b0000, 32'h0, 32'h0000_0080, 1'b0, 0);
        run(1'b0, 4'b0001, 32'h1c00_0102, 32'h0, 32'h80FF_7F01, 4'b0000, 32'h0, 32'hFFFF_80FF, 1'b0, 0);
        run(1'b0, 4'b0010, 32'h1c00_0100, 32'h0, 32'h80FF_7F01, 4'b0000, 32'h0, 32'h80FF_7F01, 1'b0, 0);
        run(1'b0, 4'b0101, 32'h1c00_0102, 32'h0, 32'h80FF_7F01, 4'b0000, 32'h0, 32'h0000_80FF, 1'b0, 0);
        run(1'b0, 4'b0001, 32'h1c00_0100, 32'h0, 32'h80FF_7F01, 4'b0000, 32'h0, 32'h0000_7F01, 1'b0, 0);

        // RD_LATENCY=3.
        run(1'b1, 4'b0010, 32'h1c00_0200, 32'h0, 32'hCAFE_F00D, 4'b0000, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
        run(1'b1, 4'b0001, 32'h1c00_0206, 32'h0, 32'h1234_8001, 4'b0000, 32'h0, 32'h0000_1234, 1'b0, 0);
        run(1'b1, 4'b0000, 32'h1c00_0204, 32'h0, 32'h1234_8081, 4'b0000, 32'h0, 32'hFFFF_FF81, 1'b0, 0);
        run(1'b1, 4'b1010, 32'h1c00_0208, 32'hA5A5_0F0F, 32'h0, 4'b1111, 32'hA5A5_0F0F, 32'h0, 1'b0, 0);

        // Misaligned / illegal size, then a normal request.
        run(1'b0, 4'b0010, 32'h1c00_0302, 32'h0, 32'h1111_2222, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
        run(1'b0, 4'b1001, 32'h1c00_0301, 32'hBEEF, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
        run(1'b0, 4'b0011, 32'h1c00_0300, 32'h0, 32'h3333_4444, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
        run(1'b1, 4'b0001, 32'h1c00_0303, 32'h0, 32'h3333_4444, 4'b0000, 32'h0, 32'h0, 1'b1, 0);
        run(1'b0, 4'b1000, 32'h1c00_0300, 32'h0000_005A, 32'h0, 4'b0001, 32'h5A5A_5A5A, 32'h0, 1'b0, 0);

        // Back-pressure from WB.
        run(1'b0, 4'b0000, 32'h1c00_0100, 32'h0, 32'h80FF_7F01, 4'b0000, 32'h0, 32'h0000_0001, 1'b0, 5);

        // Reset while a latency-3 load sits in WAIT.
        sel = 1'b1;
        exe_op = 4'b0010; exe_addr = 32'h1c00_0400; exe_dest = 5'd9; exe_pc = 32'h1c00_0900;
        sram_word = 32'h7777_8888;
        exe_valid3 = 1'b1;
        @(negedge clk);
        exe_valid3 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ready", {30'd0, rdy3, wbv3}, 32'b10);
        cnt_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wbv3 || en3 || !rdy3) cnt_bad++;
        end
        chk("rst_mid_quiet", 32'(cnt_bad), 32'd0);

        run(1'b1, 4'b0100, 32'h1c00_0401, 32'h0, 32'h7777_8888, 4'b0000, 32'h0, 32'h0000_0088, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
